// File: rtl/sata_reg_pio_fis_parser.sv
// Register D->H / PIO Setup D->H FIS parser: unpacks 5-dword frames into shadow
// registers, presents one record per good frame, and drops malformed frames.
module sata_reg_pio_fis_parser (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rx_dat,
  input  logic        rx_val,
  input  logic        rx_eop,
  input  logic        rx_err,
  output logic        rx_rdy,
  output logic        fis_val,
  input  logic        fis_rdy,
  output logic        fis_pio,
  output logic        fis_irq,
  output logic        fis_dir,
  output logic [7:0]  fis_status,
  output logic [7:0]  fis_error,
  output logic [7:0]  fis_device,
  output logic [47:0] fis_lba,
  output logic [15:0] fis_count,
  output logic [7:0]  fis_estatus,
  output logic [15:0] fis_xfer_cnt,
  output logic        bad_pulse,
  output logic [1:0]  bad_code
);

  localparam int unsigned WCNT_W = 3;
  localparam logic [7:0] TYPE_REG = 8'h34;
  localparam logic [7:0] TYPE_PIO = 8'h5F;
  localparam logic [WCNT_W-1:0] LAST_DW = WCNT_W'(4);
  localparam logic [1:0] CODE_TYPE  = 2'd0;
  localparam logic [1:0] CODE_SHORT = 2'd1;
  localparam logic [1:0] CODE_LONG  = 2'd2;
  localparam logic [1:0] CODE_ERR   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_BODY, S_DROP, S_HOLD} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WCNT_W-1:0] wcnt;
  logic [1:0]        drop_code;
  logic [1:0]        drop_code_nxt;
  logic [1:0]        code_c;
  logic              xfer_c;
  logic              type_ok_c;
  logic              last_c;
  logic              pulse_c;
  logic              commit_c;

  // Shadow copy of the frame being received
  logic              sh_pio;
  logic              sh_irq;
  logic              sh_dir;
  logic [7:0]        sh_status;
  logic [7:0]        sh_error;
  logic [7:0]        sh_device;
  logic [23:0]       sh_lba_lo;
  logic [23:0]       sh_lba_hi;
  logic [15:0]       sh_count;
  logic [7:0]        sh_estatus;

  // Ready depends on state only, so upstream never sees a path from rx_val
  assign rx_rdy    = (state != S_HOLD);
  assign xfer_c    = rx_val & rx_rdy;
  assign type_ok_c = (rx_dat[7:0] == TYPE_REG) || (rx_dat[7:0] == TYPE_PIO);
  assign last_c    = (wcnt == LAST_DW);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (xfer_c && !rx_eop) begin
          if (rx_err || !type_ok_c) state_nxt = S_DROP;
          else                      state_nxt = S_BODY;
        end
      end
      S_BODY: begin
        if (xfer_c) begin
          if (rx_eop)                 state_nxt = (last_c && !rx_err) ? S_HOLD : S_IDLE;
          else if (rx_err || last_c)  state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (xfer_c && rx_eop) state_nxt = S_IDLE;
      end
      S_HOLD: begin
        if (fis_rdy) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Drop reason priority: rx_err > unknown type > long > short; rx_err is sticky
  always_comb begin
    pulse_c       = 1'b0;
    commit_c      = 1'b0;
    code_c        = drop_code;
    drop_code_nxt = drop_code;
    case (state)
      S_IDLE: begin
        if (xfer_c) begin
          if (rx_err)          code_c = CODE_ERR;
          else if (!type_ok_c) code_c = CODE_TYPE;
          else                 code_c = CODE_SHORT;
          pulse_c       = rx_eop;
          drop_code_nxt = code_c;
        end
      end
      S_BODY: begin
        if (xfer_c) begin
          if (rx_err)      code_c = CODE_ERR;
          else if (rx_eop) code_c = CODE_SHORT;
          else             code_c = CODE_LONG;
          if (rx_eop) begin
            commit_c = last_c & ~rx_err;
            pulse_c  = ~(last_c & ~rx_err);
          end
          drop_code_nxt = code_c;
        end
      end
      S_DROP: begin
        if (xfer_c) begin
          if (rx_err) code_c = CODE_ERR;
          pulse_c       = rx_eop;
          drop_code_nxt = code_c;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt         <= '0;
      drop_code    <= '0;
      bad_pulse    <= 1'b0;
      bad_code     <= '0;
      fis_val      <= 1'b0;
      sh_pio       <= 1'b0;
      sh_irq       <= 1'b0;
      sh_dir       <= 1'b0;
      sh_status    <= '0;
      sh_error     <= '0;
      sh_device    <= '0;
      sh_lba_lo    <= '0;
      sh_lba_hi    <= '0;
      sh_count     <= '0;
      sh_estatus   <= '0;
      fis_pio      <= 1'b0;
      fis_irq      <= 1'b0;
      fis_dir      <= 1'b0;
      fis_status   <= '0;
      fis_error    <= '0;
      fis_device   <= '0;
      fis_lba      <= '0;
      fis_count    <= '0;
      fis_estatus  <= '0;
      fis_xfer_cnt <= '0;
    end else begin
      bad_pulse <= pulse_c;
      if (pulse_c) bad_code <= code_c;
      drop_code <= drop_code_nxt;
      fis_val   <= (state_nxt == S_HOLD);

      if (xfer_c && state == S_IDLE) begin
        wcnt      <= WCNT_W'(1);
        sh_pio    <= (rx_dat[7:0] == TYPE_PIO);
        sh_irq    <= rx_dat[14];
        sh_dir    <= rx_dat[13];
        sh_status <= rx_dat[23:16];
        sh_error  <= rx_dat[31:24];
      end else if (xfer_c && state == S_BODY) begin
        wcnt <= wcnt + WCNT_W'(1);
        case (wcnt)
          3'd1: begin
            sh_device <= rx_dat[31:24];
            sh_lba_lo <= rx_dat[23:0];
          end
          3'd2: sh_lba_hi <= rx_dat[23:0];
          3'd3: begin
            sh_count   <= rx_dat[15:0];
            sh_estatus <= rx_dat[31:24];
          end
          default: ;
        endcase
      end

      // DW4 is taken straight from the bus on the eop beat
      if (commit_c) begin
        fis_pio      <= sh_pio;
        fis_irq      <= sh_irq;
        fis_dir      <= sh_pio & sh_dir;
        fis_status   <= sh_status;
        fis_error    <= sh_error;
        fis_device   <= sh_device;
        fis_lba      <= {sh_lba_hi, sh_lba_lo};
        fis_count    <= sh_count;
        fis_estatus  <= sh_pio ? sh_estatus : 8'h00;
        fis_xfer_cnt <= sh_pio ? rx_dat[15:0] : 16'h0000;
      end
    end
  end

endmodule

// File: tb/tb_sata_reg_pio_fis_parser.sv
// Self-checking bench for sata_reg_pio_fis_parser: table of whole frames plus
// hand sequences for HOLD back-pressure, back-to-back streaming and reset.
module tb_sata_reg_pio_fis_parser;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rx_dat;
  logic        rx_val;
  logic        rx_eop;
  logic        rx_err;
  logic        rx_rdy;
  logic        fis_val;
  logic        fis_rdy;
  logic        fis_pio;
  logic        fis_irq;
  logic        fis_dir;
  logic [7:0]  fis_status;
  logic [7:0]  fis_error;
  logic [7:0]  fis_device;
  logic [47:0] fis_lba;
  logic [15:0] fis_count;
  logic [7:0]  fis_estatus;
  logic [15:0] fis_xfer_cnt;
  logic        bad_pulse;
  logic [1:0]  bad_code;

  always #5 clk = ~clk;

  sata_reg_pio_fis_parser dut (
    .clk(clk), .reset(reset),
    .rx_dat(rx_dat), .rx_val(rx_val), .rx_eop(rx_eop), .rx_err(rx_err), .rx_rdy(rx_rdy),
    .fis_val(fis_val), .fis_rdy(fis_rdy), .fis_pio(fis_pio), .fis_irq(fis_irq),
    .fis_dir(fis_dir), .fis_status(fis_status), .fis_error(fis_error),
    .fis_device(fis_device), .fis_lba(fis_lba), .fis_count(fis_count),
    .fis_estatus(fis_estatus), .fis_xfer_cnt(fis_xfer_cnt),
    .bad_pulse(bad_pulse), .bad_code(bad_code)
  );

  typedef struct packed {
    logic        pio;
    logic        irq;
    logic        dir;
    logic [7:0]  status;
    logic [7:0]  error;
    logic [7:0]  device;
    logic [47:0] lba;
    logic [15:0] count;
    logic [7:0]  estatus;
    logic [15:0] xfer;
  } fld_t;

  typedef struct {
    int          n;
    logic [31:0] dw [8];
    int          err_at;
    bit          good;
    logic [1:0]  code;
    fld_t        exp;
  } vec_t;

  localparam int NVEC = 11;

  vec_t vecs [NVEC];
  fld_t dut_fld;
  fld_t last_good;
  int   checks = 0;
  int   failures = 0;

  assign dut_fld = {fis_pio, fis_irq, fis_dir, fis_status, fis_error, fis_device,
                    fis_lba, fis_count, fis_estatus, fis_xfer_cnt};

  function automatic fld_t mkf(input logic pio, input logic irq, input logic dir,
                               input logic [7:0] status, input logic [7:0] error,
                               input logic [7:0] device, input logic [47:0] lba,
                               input logic [15:0] count, input logic [7:0] estatus,
                               input logic [15:0] xfer);
    fld_t f;
    f = {pio, irq, dir, status, error, device, lba, count, estatus, xfer};
    return f;
  endfunction

  function automatic vec_t mk(input int n, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3,
                              input logic [31:0] d4, input logic [31:0] d5,
                              input logic [31:0] d6, input int err_at, input bit good,
                              input logic [1:0] code, input fld_t e);
    vec_t v;
    v.n = n;
    v.dw[0] = d0; v.dw[1] = d1; v.dw[2] = d2; v.dw[3] = d3;
    v.dw[4] = d4; v.dw[5] = d5; v.dw[6] = d6; v.dw[7] = 32'h0;
    v.err_at = err_at;
    v.good = good;
    v.code = code;
    v.exp = e;
    return v;
  endfunction

  task automatic chk(input string nm, input int id, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", nm, id, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_fields"}, -1, 128'(dut_fld), 128'(0));
    chk({nm, "_fis_val"}, -1, 128'(fis_val), 128'(0));
    chk({nm, "_bad_pulse"}, -1, 128'(bad_pulse), 128'(0));
    chk({nm, "_bad_code"}, -1, 128'(bad_code), 128'(0));
    chk({nm, "_rx_rdy"}, -1, 128'(rx_rdy), 128'(1));
  endtask

  // Stream one frame with rx_val continuous, then check the resulting record or drop
  task automatic run_vec(input vec_t v, input int id, input int hold);
    bit rdy_ok;
    bit stable;
    rdy_ok = 1'b1;
    for (int i = 0; i < v.n; i++) begin
      rx_val = 1'b1;
      rx_dat = v.dw[i];
      rx_eop = (i == v.n - 1);
      rx_err = (i == v.err_at);
      if (rx_rdy !== 1'b1) rdy_ok = 1'b0;
      @(posedge clk); #1;
    end
    rx_val = 1'b0; rx_eop = 1'b0; rx_err = 1'b0;
    chk("rdy_during_frame", id, 128'(rdy_ok), 128'(1));
    if (v.good) begin
      chk("fis_val_rise", id, 128'(fis_val), 128'(1));
      chk("fields", id, 128'(dut_fld), 128'(v.exp));
      chk("no_bad_pulse", id, 128'(bad_pulse), 128'(0));
      chk("rdy_low_in_hold", id, 128'(rx_rdy), 128'(0));
      last_good = v.exp;
      if (hold > 0) begin
        stable = 1'b1;
        // Offer a 1-dword frame during HOLD; it must not be taken
        rx_val = 1'b1; rx_dat = 32'h00504034; rx_eop = 1'b1;
        repeat (hold) begin
          @(posedge clk); #1;
          if (fis_val !== 1'b1 || rx_rdy !== 1'b0 || dut_fld !== v.exp || bad_pulse !== 1'b0)
            stable = 1'b0;
        end
        rx_val = 1'b0; rx_eop = 1'b0;
        chk("hold_stable", id, 128'(stable), 128'(1));
      end
      fis_rdy = 1'b1;
      @(posedge clk); #1;
      fis_rdy = 1'b0;
      chk("fis_val_fall", id, 128'(fis_val), 128'(0));
      chk("rdy_after_accept", id, 128'(rx_rdy), 128'(1));
      chk("fields_held", id, 128'(dut_fld), 128'(v.exp));
    end else begin
      chk("bad_pulse", id, 128'(bad_pulse), 128'(1));
      chk("bad_code", id, 128'(bad_code), 128'(v.code));
      chk("no_fis_val", id, 128'(fis_val), 128'(0));
      chk("fields_kept", id, 128'(dut_fld), 128'(last_good));
      @(posedge clk); #1;
      chk("bad_pulse_one_cycle", id, 128'(bad_pulse), 128'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w [15];
    fld_t        bexp [3];
    int          ptr;
    int          rec;
    int          cyc;
    bit          will;
    bit          bad_seen;

    vecs[0]  = mk(5, 32'h00504034, 32'hE0123456, 32'h00000078, 32'h00000010, 32'h0, 32'h0, 32'h0,
                  -1, 1'b1, 2'd0,
                  mkf(1'b0, 1'b1, 1'b0, 8'h50, 8'h00, 8'hE0, 48'h000078123456, 16'h0010, 8'h00, 16'h0000));
    vecs[1]  = mk(5, 32'h0058605F, 32'hA0000000, 32'h00000001, 32'h50000001, 32'h00000200, 32'h0, 32'h0,
                  -1, 1'b1, 2'd0,
                  mkf(1'b1, 1'b1, 1'b1, 8'h58, 8'h00, 8'hA0, 48'h000001000000, 16'h0001, 8'h50, 16'h0200));
    vecs[2]  = mk(3, 32'h00504034, 32'hE0000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, -1, 1'b0, 2'd1, '0);
    vecs[3]  = mk(7, 32'h00504034, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                  32'h55555555, 32'h66666666, -1, 1'b0, 2'd2, '0);
    vecs[4]  = mk(5, 32'h0058605F, 32'hA0000000, 32'h00000001, 32'h50000001, 32'h00000200, 32'h0, 32'h0,
                  2, 1'b0, 2'd3, '0);
    vecs[5]  = mk(1, 32'h00000041, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, -1, 1'b0, 2'd0, '0);
    vecs[6]  = mk(1, 32'h00504034, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, -1, 1'b0, 2'd1, '0);
    vecs[7]  = mk(2, 32'h00000041, 32'h12345678, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 1'b0, 2'd3, '0);
    vecs[8]  = mk(6, 32'h00504034, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h0, 5, 1'b0, 2'd3, '0);
    vecs[9]  = mk(5, 32'h7F512034, 32'h40ABCDEF, 32'hFF112233, 32'hAA00BEEF, 32'h12345678, 32'h0, 32'h0,
                  -1, 1'b1, 2'd0,
                  mkf(1'b0, 1'b0, 1'b0, 8'h51, 8'h7F, 8'h40, 48'h112233ABCDEF, 16'hBEEF, 8'h00, 16'h0000));
    vecs[10] = mk(4, 32'h00504034, 32'h1, 32'h2, 32'h3, 32'h0, 32'h0, 32'h0, 3, 1'b0, 2'd3, '0);

    reset = 1'b1; rx_dat = '0; rx_val = 1'b0; rx_eop = 1'b0; rx_err = 1'b0; fis_rdy = 1'b0;
    last_good = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_zero("reset");

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i, 0);

    // PIO record held under back-pressure
    run_vec(vecs[1], 101, 10);

    // Back-to-back frames, fis_rdy tied high, rx_val continuous
    for (int i = 0; i < 5; i++) begin
      w[i] = vecs[0].dw[i]; w[i+5] = vecs[1].dw[i]; w[i+10] = vecs[9].dw[i];
    end
    bexp[0] = vecs[0].exp; bexp[1] = vecs[1].exp; bexp[2] = vecs[9].exp;
    fis_rdy = 1'b1; ptr = 0; rec = 0; cyc = 0; bad_seen = 1'b0;
    while (rec < 3 && cyc < 60) begin
      if (ptr < 15) begin
        rx_val = 1'b1; rx_dat = w[ptr]; rx_eop = (ptr % 5 == 4);
      end else begin
        rx_val = 1'b0; rx_eop = 1'b0;
      end
      will = rx_rdy && (ptr < 15);
      @(posedge clk); #1;
      cyc++;
      if (will) ptr++;
      if (bad_pulse) bad_seen = 1'b1;
      if (fis_val) begin
        chk("b2b_record", rec, 128'(dut_fld), 128'(bexp[rec]));
        rec++;
      end
    end
    rx_val = 1'b0; rx_eop = 1'b0; fis_rdy = 1'b0;
    last_good = vecs[9].exp;
    chk("b2b_records", -1, 128'(rec), 128'(3));
    chk("b2b_words", -1, 128'(ptr), 128'(15));
    chk("b2b_cycles", -1, 128'(cyc), 128'(17));
    chk("b2b_no_bad", -1, 128'(bad_seen), 128'(0));
    @(posedge clk); #1;

    // Reset while DW2 of a good frame is on the bus
    for (int i = 0; i < 2; i++) begin
      rx_val = 1'b1; rx_dat = vecs[0].dw[i]; rx_eop = 1'b0;
      @(posedge clk); #1;
    end
    rx_dat = vecs[0].dw[2]; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; rx_val = 1'b0;
    chk_zero("rst_mid");
    last_good = '0;
    @(posedge clk); #1;
    chk("rst_mid_no_pulse", -1, 128'(bad_pulse), 128'(0));
    run_vec(vecs[9], 109, 0);

    // Reset during HOLD
    for (int i = 0; i < 5; i++) begin
      rx_val = 1'b1; rx_dat = vecs[0].dw[i]; rx_eop = (i == 4);
      @(posedge clk); #1;
    end
    rx_val = 1'b0; rx_eop = 1'b0;
    chk("hold_before_reset", -1, 128'(fis_val), 128'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_zero("rst_hold");
    last_good = '0;
    @(posedge clk); #1;
    chk("rst_hold_no_pulse", -1, 128'(bad_pulse), 128'(0));
    run_vec(vecs[1], 111, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
